// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave answering single-beat and INCR burst reads/writes out of a
// single-port synchronous SRAM with 1-cycle read latency. One transaction in flight at a time.
// When AW and AR arrive together, the accepted direction alternates.
// Build option: define AXI_SRAM_RANGE_CHK_EN to decode the SRAM window and answer misses with DECERR.
module axi_sram_slave #(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DATA_WIDTH = 64,
   parameter int unsigned            ID_WIDTH   = 4,
   parameter int unsigned            SRAM_AW    = 12,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   // write address channel
   input  logic                      aw_valid,
   output logic                      aw_ready,
   input  logic [ID_WIDTH-1:0]       aw_id,
   input  logic [ADDR_WIDTH-1:0]     aw_addr,
   input  logic [7:0]                aw_len,
   input  logic [2:0]                aw_size,
   input  logic [1:0]                aw_burst,
   // write data channel
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic [DATA_WIDTH-1:0]     w_data,
   input  logic [DATA_WIDTH/8-1:0]   w_strb,
   input  logic                      w_last,
   // write response channel
   output logic                      b_valid,
   input  logic                      b_ready,
   output logic [ID_WIDTH-1:0]       b_id,
   output logic [1:0]                b_resp,
   // read address channel
   input  logic                      ar_valid,
   output logic                      ar_ready,
   input  logic [ID_WIDTH-1:0]       ar_id,
   input  logic [ADDR_WIDTH-1:0]     ar_addr,
   input  logic [7:0]                ar_len,
   input  logic [2:0]                ar_size,
   input  logic [1:0]                ar_burst,
   // read data channel
   output logic                      r_valid,
   input  logic                      r_ready,
   output logic [ID_WIDTH-1:0]       r_id,
   output logic [DATA_WIDTH-1:0]     r_data,
   output logic [1:0]                r_resp,
   output logic                      r_last,
   // SRAM macro port
   output logic                      o_sram_en,
   output logic                      o_sram_we,
   output logic [SRAM_AW-1:0]        o_sram_addr,
   output logic [DATA_WIDTH-1:0]     o_sram_wdata,
   output logic [DATA_WIDTH/8-1:0]   o_sram_wmask,
   input  logic [DATA_WIDTH-1:0]     i_sram_rdata
);

   localparam int unsigned STRB      = DATA_WIDTH / 8;
   localparam int unsigned STRB_LSB  = $clog2(STRB);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic        PRIO_WRITE  = 1'b0;
   localparam logic        PRIO_READ   = 1'b1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      W_DATA  = 3'd1,
      W_RESP  = 3'd2,
      R_ISSUE = 3'd3,
      R_WAIT  = 3'd4,
      R_DATA  = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic                    prio_q, prio_d;
   logic [ID_WIDTH-1:0]     id_q, id_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              len_q, len_d;
   logic [2:0]              size_q, size_d;
   logic [1:0]              burst_q, burst_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [1:0]              resp_q, resp_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    hit_c;
   logic                    last_beat_c;
   logic [ADDR_WIDTH-1:0]   addr_next_c;

`ifdef AXI_SRAM_RANGE_CHK_EN
   localparam longint unsigned WIN_BYTES = 64'(STRB) << SRAM_AW;

   logic hit_q, hit_d;

   // true when a byte address falls inside the SRAM window
   function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
      return (a >= BASE_ADDR) && (64'(a - BASE_ADDR) < WIN_BYTES);
   endfunction

   assign hit_c = hit_q;
`else
   assign hit_c = 1'b1;
`endif

   // current beat is the last one the AW/AR length announced
   assign last_beat_c = (cnt_q == len_q);
   // next beat address: FIXED holds, INCR and WRAP both step by the beat size
   assign addr_next_c = (burst_q == BURST_FIXED) ? addr_q : addr_q + (ADDR_WIDTH'(1) << size_q);

   // SRAM word address and pass-through write path
   assign o_sram_addr  = SRAM_AW'((addr_q - BASE_ADDR) >> STRB_LSB);
   assign o_sram_wdata = w_data;
   assign o_sram_wmask = w_strb;

   // response payloads come straight from the latched transaction state
   assign b_id   = id_q;
   assign b_resp = resp_q;
   assign r_id   = id_q;
   assign r_resp = resp_q;
   assign r_data = rdata_q;
   assign r_last = last_beat_c;

   // transaction state register with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         prio_q  <= PRIO_WRITE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         resp_q  <= RESP_OKAY;
         rdata_q <= '0;
`ifdef AXI_SRAM_RANGE_CHK_EN
         hit_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
         rdata_q <= rdata_d;
`ifdef AXI_SRAM_RANGE_CHK_EN
         hit_q   <= hit_d;
`endif
      end
   end

   // next-state, handshake and SRAM strobe decode
   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      id_d      = id_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      cnt_d     = cnt_q;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
`ifdef AXI_SRAM_RANGE_CHK_EN
      hit_d     = hit_q;
`endif
      aw_ready  = 1'b0;
      ar_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      r_valid   = 1'b0;
      o_sram_en = 1'b0;
      o_sram_we = 1'b0;

      case (state_q)
         IDLE: begin
            aw_ready = aw_valid && (!ar_valid || (prio_q == PRIO_WRITE));
            ar_ready = ar_valid && (!aw_valid || (prio_q == PRIO_READ));
            if (aw_ready) begin
               id_d    = aw_id;
               addr_d  = aw_addr;
               len_d   = aw_len;
               size_d  = aw_size;
               burst_d = aw_burst;
               cnt_d   = '0;
               resp_d  = RESP_OKAY;
               prio_d  = PRIO_READ;
               state_d = W_DATA;
`ifdef AXI_SRAM_RANGE_CHK_EN
               hit_d   = in_window(aw_addr);
               if (!in_window(aw_addr)) resp_d = RESP_DECERR;
`endif
            end else if (ar_ready) begin
               id_d    = ar_id;
               addr_d  = ar_addr;
               len_d   = ar_len;
               size_d  = ar_size;
               burst_d = ar_burst;
               cnt_d   = '0;
               resp_d  = RESP_OKAY;
               prio_d  = PRIO_WRITE;
               state_d = R_ISSUE;
`ifdef AXI_SRAM_RANGE_CHK_EN
               hit_d   = in_window(ar_addr);
               if (!in_window(ar_addr)) resp_d = RESP_DECERR;
`endif
            end
         end
         W_DATA: begin
            w_ready   = 1'b1;
            o_sram_we = 1'b1;
            if (w_valid) begin
               o_sram_en = hit_c;
               addr_d    = addr_next_c;
               cnt_d     = cnt_q + 8'd1;
               // early or missing w_last still writes the beat but flags the burst
               if ((w_last != last_beat_c) && (resp_q != RESP_DECERR)) resp_d = RESP_SLVERR;
               if (w_last) state_d = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (b_ready) begin
               resp_d  = RESP_OKAY;
               state_d = IDLE;
            end
         end
         R_ISSUE: begin
            o_sram_en = hit_c;
            state_d   = R_WAIT;
         end
         R_WAIT: begin
            rdata_d = hit_c ? i_sram_rdata : '0;
            state_d = R_DATA;
         end
         R_DATA: begin
            r_valid = 1'b1;
            if (r_ready) begin
               if (last_beat_c) begin
                  resp_d  = RESP_OKAY;
                  state_d = IDLE;
               end else begin
                  addr_d  = addr_next_c;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = R_ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // nothing handshakes or touches the SRAM while reset is held
      if (!i_rst_n) begin
         aw_ready  = 1'b0;
         ar_ready  = 1'b0;
         w_ready   = 1'b0;
         b_valid   = 1'b0;
         r_valid   = 1'b0;
         o_sram_en = 1'b0;
         o_sram_we = 1'b0;
      end
   end

endmodule
